// File: rtl/oddr141_tx_ctrl.sv
// Sequencer and word source for a 14:1 DDR output gearbox: reset/sync sequence,
// training pattern, then user words, with a programmable bit-slip across word boundaries.
module oddr141_tx_ctrl #(
    parameter int unsigned GB_RST_CYCLES = 4,
    parameter int unsigned SYNC_CYCLES   = 8,
    parameter int unsigned TRAIN_WORDS   = 64,
    parameter logic [13:0] TRAIN_PATTERN = 14'h3F80,
    parameter logic [13:0] IDLE_PATTERN  = 14'h0000
) (
    input  logic        SCLK,
    input  logic        RST,
    input  logic        en,
    input  logic        train_req,
    input  logic        slip,
    input  logic [13:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        GB_RST,
    output logic [13:0] DOUT,
    output logic [1:0]  state,
    output logic        train_done,
    output logic [3:0]  slip_offset
);

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_SYNC       = 2'd1,
        ST_TRAIN      = 2'd2,
        ST_DATA       = 2'd3
    } state_t;

    localparam logic [15:0] GB_LAST    = 16'(GB_RST_CYCLES - 1);
    localparam logic [15:0] SYNC_LAST  = 16'(SYNC_CYCLES - 1);
    localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_WORDS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [13:0] prev_q, prev_d;
    logic [13:0] dout_q, dout_d;
    logic [3:0]  slip_q, slip_d;
    logic [13:0] cur;
    logic [27:0] win;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slip_d  = slip_q;
        cur     = IDLE_PATTERN;

        case (state_q)
            ST_RESET_HOLD: begin
                if (cnt_q == GB_LAST) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = ST_TRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_TRAIN: begin
                cur = TRAIN_PATTERN;
                if (cnt_q == TRAIN_LAST) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                if (s_valid) cur = s_data;
                if (train_req) begin
                    state_d = ST_TRAIN;
                    cnt_d   = '0;
                end
            end
        endcase

        if ((state_q == ST_TRAIN || state_q == ST_DATA) && slip)
            slip_d = (slip_q == 4'd13) ? 4'd0 : slip_q + 4'd1;

        // Shifting {cur, prev} left by k and taking the top half selects W[27-k -: 14].
        win    = {cur, prev_q} << slip_q;
        dout_d = win[27:14];
        prev_d = cur;

        if (state_q == ST_RESET_HOLD) begin
            dout_d = IDLE_PATTERN;
            prev_d = IDLE_PATTERN;
        end

        if (!en) begin
            state_d = ST_RESET_HOLD;
            cnt_d   = '0;
            slip_d  = '0;
            dout_d  = IDLE_PATTERN;
            prev_d  = IDLE_PATTERN;
        end
    end

    always_ff @(posedge SCLK) begin
        if (RST) begin
            state_q <= ST_RESET_HOLD;
            cnt_q   <= '0;
            prev_q  <= IDLE_PATTERN;
            dout_q  <= IDLE_PATTERN;
            slip_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            dout_q  <= dout_d;
            slip_q  <= slip_d;
        end
    end

    assign s_ready     = (state_q == ST_DATA);
    assign train_done  = (state_q == ST_DATA);
    assign GB_RST      = (state_q == ST_RESET_HOLD);
    assign state       = state_q;
    assign DOUT        = dout_q;
    assign slip_offset = slip_q;

endmodule

// File: tb/tb_oddr141_tx_ctrl.sv
// Scoreboard bench for oddr141_tx_ctrl: stimulus pushes the expected post-edge outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_oddr141_tx_ctrl;

    logic        SCLK = 1'b0;
    logic        RST = 1'b1;
    logic        en = 1'b0;
    logic        train_req = 1'b0;
    logic        slip = 1'b0;
    logic [13:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        GB_RST;
    logic [13:0] DOUT;
    logic [1:0]  state;
    logic        train_done;
    logic [3:0]  slip_offset;

    oddr141_tx_ctrl #(
        .GB_RST_CYCLES(4),
        .SYNC_CYCLES  (8),
        .TRAIN_WORDS  (64),
        .TRAIN_PATTERN(14'h3F80),
        .IDLE_PATTERN (14'h0000)
    ) dut (
        .SCLK       (SCLK),
        .RST        (RST),
        .en         (en),
        .train_req  (train_req),
        .slip       (slip),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .GB_RST     (GB_RST),
        .DOUT       (DOUT),
        .state      (state),
        .train_done (train_done),
        .slip_offset(slip_offset)
    );

    always #5 SCLK = ~SCLK;

    typedef struct {
        int unsigned due;
        string       nm;
        logic [13:0] dout;
        logic [1:0]  st;
        logic        gb;
        logic        rdy;
        logic        done;
        logic [3:0]  off;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always @(posedge SCLK) cyc <= cyc + 1;

    always @(negedge SCLK) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.due != cyc ||
                {DOUT, state, GB_RST, s_ready, train_done, slip_offset} !==
                {e.dout, e.st, e.gb, e.rdy, e.done, e.off}) begin
                $display("FAIL %s cyc=%0d due=%0d: got DOUT=%h st=%0d gb=%b rdy=%b done=%b off=%0d, want DOUT=%h st=%0d gb=%b rdy=%b done=%b off=%0d",
                         e.nm, cyc, e.due, DOUT, state, GB_RST, s_ready, train_done, slip_offset,
                         e.dout, e.st, e.gb, e.rdy, e.done, e.off);
            end else begin
                n_pass++;
            end
        end
        if (cyc > 5000) begin
            $display("FAIL watchdog: cyc=%0d exceeded limit 5000", cyc);
            $fatal(1, "watchdog");
        end
    end

    function automatic logic [13:0] rot(logic [13:0] cur, logic [13:0] prev, int unsigned k);
        logic [27:0] w;
        logic [13:0] r;
        w = {cur, prev};
        for (int unsigned i = 0; i < 14; i++) r[i] = w[14 - k + i];
        return r;
    endfunction

    task automatic expect_next(string nm, logic [13:0] d, logic [1:0] st, logic gb,
                               logic rdy, logic done, logic [3:0] off);
        exp_t x;
        x.due  = cyc + 1;
        x.nm   = nm;
        x.dout = d;
        x.st   = st;
        x.gb   = gb;
        x.rdy  = rdy;
        x.done = done;
        x.off  = off;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge SCLK);
        #1;
    endtask

    task automatic startup();
        RST = 0; en = 1; train_req = 0; slip = 0; s_valid = 0;
        for (int i = 0; i < 4; i++) begin
            expect_next("rst_hold", 14'h0000, (i == 3) ? 2'd1 : 2'd0, (i == 3) ? 1'b0 : 1'b1, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            expect_next("sync", 14'h0000, (i == 7) ? 2'd2 : 2'd1, 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 64; i++) begin
            expect_next("train", 14'h3F80, (i == 63) ? 2'd3 : 2'd2, 0, i == 63, i == 63, 0);
            tick();
        end
    endtask

    logic [13:0] t3_head [5];
    logic [13:0] prev_m;
    logic [13:0] d_m;
    int unsigned k_m;

    initial begin
        t3_head[0] = 14'h3F80; t3_head[1] = 14'h3F01; t3_head[2] = 14'h3E03;
        t3_head[3] = 14'h3C07; t3_head[4] = 14'h3C07;

        // reset then power-up sequence
        for (int i = 0; i < 3; i++) begin
            expect_next("reset", 14'h0000, 0, 1, 0, 0, 0);
            tick();
        end
        startup();

        // streaming data
        s_valid = 1;
        s_data = 14'h0001; expect_next("data_0001", 14'h0001, 3, 0, 1, 1, 0); tick();
        s_data = 14'h2AAA; expect_next("data_2AAA", 14'h2AAA, 3, 0, 1, 1, 0); tick();
        s_data = 14'h1555; expect_next("data_1555", 14'h1555, 3, 0, 1, 1, 0); tick();
        s_valid = 0;
        for (int i = 0; i < 2; i++) begin
            expect_next("data_idle", 14'h0000, 3, 0, 1, 1, 0);
            tick();
        end

        // retrain request with a word in flight
        s_valid = 1; s_data = 14'h0ABC; train_req = 1;
        expect_next("trreq_word", 14'h0ABC, 2, 0, 0, 0, 0);
        tick();
        train_req = 0; s_data = 14'h3FFF;
        for (int i = 0; i < 64; i++) begin
            expect_next("trreq_train", 14'h3F80, (i == 63) ? 2'd3 : 2'd2, 0, i == 63, i == 63, 0);
            tick();
        end
        s_valid = 0;

        // slip in TRAIN: 3 pulses, hold, then 11 more to wrap
        train_req = 1;
        expect_next("tr3_entry", 14'h0000, 2, 0, 0, 0, 0);
        tick();
        train_req = 0;
        prev_m = 14'h0000;
        k_m = 0;
        for (int i = 0; i < 64; i++) begin
            slip = (i < 3) || (i >= 5 && i < 16);
            d_m = (i < 5) ? t3_head[i] : rot(14'h3F80, prev_m, k_m);
            if (slip) k_m = (k_m + 1) % 14;
            expect_next("slip_train", d_m, (i == 63) ? 2'd3 : 2'd2, 0, i == 63, i == 63, 4'(k_m));
            prev_m = 14'h3F80;
            tick();
        end
        slip = 0;

        // slip in DATA, slip on the train_req edge, offset kept into TRAIN
        slip = 1;
        expect_next("data_slip", 14'h0000, 3, 0, 1, 1, 1);
        tick();
        train_req = 1; s_valid = 1; s_data = 14'h1234;
        expect_next("slip_at_trreq", 14'h2468, 2, 0, 0, 0, 2);
        tick();
        train_req = 0; slip = 0; s_valid = 0;
        for (int i = 0; i < 20; i++) begin
            expect_next("train_k2", (i == 0) ? 14'h3E01 : 14'h3E03, 2, 0, 0, 0, 2);
            tick();
        end

        // en dropped mid-TRAIN, then full restart
        en = 0;
        for (int i = 0; i < 2; i++) begin
            expect_next("en_drop", 14'h0000, 0, 1, 0, 0, 0);
            tick();
        end
        startup();

        // RST in DATA with s_valid and slip
        RST = 1; s_valid = 1; s_data = 14'h1555; slip = 1;
        expect_next("rst_in_data", 14'h0000, 0, 1, 0, 0, 0);
        tick();
        RST = 0; s_valid = 0; slip = 0;
        expect_next("after_rst", 14'h0000, 0, 1, 0, 0, 0);
        tick();

        repeat (2) tick();
        n_checks++;
        if (sb.size() != 0)
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
